// File: rtl/glb_fps_port.sv
// Global-buffer responder for one FPS SRAM channel: single-port word array with
// write-priority arbitration and a 2-entry read-data FIFO absorbing back-pressure.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where both valid and ready are high; ready never depends on its own valid.
module glb_fps_port #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 92
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUGLB_Rst,
    input  logic [ADDR_WIDTH-1:0] FPSGLB_RdAddr,
    input  logic                  FPSGLB_RdAddrVld,
    output logic                  GLBFPS_RdAddrRdy,
    output logic [DATA_WIDTH-1:0] GLBFPS_RdDat,
    output logic                  GLBFPS_RdDatVld,
    input  logic                  FPSGLB_RdDatRdy,
    input  logic [ADDR_WIDTH-1:0] FPSGLB_WrAddr,
    input  logic [DATA_WIDTH-1:0] FPSGLB_WrDat,
    input  logic                  FPSGLB_WrDatVld,
    output logic                  GLBFPS_WrDatRdy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [DATA_WIDTH-1:0] fifo_q [0:1];
    logic [DATA_WIDTH-1:0] fifo_d [0:1];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    logic                  pop;
    logic                  push;
    logic                  wr_fire;
    logic                  room;
    logic [1:0]            occ_after_pop;
    logic [DATA_WIDTH-1:0] rd_word;

    assign GLBFPS_RdDatVld = (occ_q != 2'd0);
    assign GLBFPS_RdDat    = fifo_q[head_q];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts a read.
    assign pop           = GLBFPS_RdDatVld & FPSGLB_RdDatRdy;
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign room          = (occ_after_pop < 2'd2);

    assign GLBFPS_WrDatRdy  = ~CCUGLB_Rst;
    assign GLBFPS_RdAddrRdy = ~CCUGLB_Rst & ~FPSGLB_WrDatVld & room;

    assign wr_fire = FPSGLB_WrDatVld & GLBFPS_WrDatRdy;
    assign push    = FPSGLB_RdAddrVld & GLBFPS_RdAddrRdy;
    assign rd_word = mem[FPSGLB_RdAddr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[FPSGLB_WrAddr] <= FPSGLB_WrDat;
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (CCUGLB_Rst) begin
            fifo_d[0] = '0;
            fifo_d[1] = '0;
            head_d    = 1'b0;
            tail_d    = 1'b0;
            occ_d     = 2'd0;
        end else begin
            if (push) begin
                fifo_d[tail_q] = rd_word;
                tail_d         = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            occ_d = occ_after_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_glb_fps_port.sv
// Directed bench for glb_fps_port: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_glb_fps_port;

    localparam int AW = 10;
    localparam int DW = 92;

    logic          clk;
    logic          rst_n;
    logic          ccu_rst;
    logic [AW-1:0] rd_addr;
    logic          rd_addr_vld;
    logic          rd_addr_rdy;
    logic [DW-1:0] rd_dat;
    logic          rd_dat_vld;
    logic          rd_dat_rdy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          wr_dat_vld;
    logic          wr_dat_rdy;

    int n_assert;
    int n_fail;

    glb_fps_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .CCUGLB_Rst       (ccu_rst),
        .FPSGLB_RdAddr    (rd_addr),
        .FPSGLB_RdAddrVld (rd_addr_vld),
        .GLBFPS_RdAddrRdy (rd_addr_rdy),
        .GLBFPS_RdDat     (rd_dat),
        .GLBFPS_RdDatVld  (rd_dat_vld),
        .FPSGLB_RdDatRdy  (rd_dat_rdy),
        .FPSGLB_WrAddr    (wr_addr),
        .FPSGLB_WrDat     (wr_dat),
        .FPSGLB_WrDatVld  (wr_dat_vld),
        .GLBFPS_WrDatRdy  (wr_dat_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        ccu_rst     = 1'b0;
        rd_addr     = '0;
        rd_addr_vld = 1'b0;
        rd_dat_rdy  = 1'b0;
        wr_addr     = '0;
        wr_dat      = '0;
        wr_dat_vld  = 1'b0;

        // Reset state
        #2;
        chk("rst_rdvld", DW'(rd_dat_vld), DW'(0));
        chk("rst_rddat", rd_dat, DW'(0));
        chk("rst_wrrdy", DW'(wr_dat_rdy), DW'(1));
        chk("rst_rdrdy", DW'(rd_addr_rdy), DW'(1));
        wr_dat_vld = 1'b1;
        #1;
        chk("rst_rdrdy_wrvld", DW'(rd_addr_rdy), DW'(0));
        wr_dat_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Write 0x2A5 @5 and 0x1 @1023, then read both back
        wr_dat_vld = 1'b1; wr_addr = 10'd5; wr_dat = DW'(32'h2A5);
        settle();
        chk("wr1_wrrdy", DW'(wr_dat_rdy), DW'(1));
        chk("wr1_rdrdy", DW'(rd_addr_rdy), DW'(0));
        cyc();
        wr_addr = 10'd1023; wr_dat = DW'(1);
        cyc();
        wr_dat_vld = 1'b0;
        rd_addr_vld = 1'b1; rd_addr = 10'd5; rd_dat_rdy = 1'b1;
        settle();
        chk("rd1_rdrdy", DW'(rd_addr_rdy), DW'(1));
        chk("rd1_vld0", DW'(rd_dat_vld), DW'(0));
        cyc();
        rd_addr = 10'd1023;
        settle();
        chk("rd1_vld", DW'(rd_dat_vld), DW'(1));
        chk("rd1_dat", rd_dat, DW'(32'h2A5));
        chk("rd2_rdrdy", DW'(rd_addr_rdy), DW'(1));
        cyc();
        rd_addr_vld = 1'b0;
        settle();
        chk("rd2_vld", DW'(rd_dat_vld), DW'(1));
        chk("rd2_dat", rd_dat, DW'(1));
        cyc();
        chk("rd2_empty", DW'(rd_dat_vld), DW'(0));

        // Fill addr 0..15 with 0x100+i, then burst-read them with no bubbles
        wr_dat_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_addr = AW'(i); wr_dat = DW'(32'h100 + i);
            cyc();
        end
        wr_dat_vld = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            rd_addr_vld = (i < 16);
            rd_addr = AW'(i);
            settle();
            if (i < 16) chk("burst_rdrdy", DW'(rd_addr_rdy), DW'(1));
            if (i > 0) begin
                chk("burst_vld", DW'(rd_dat_vld), DW'(1));
                chk("burst_dat", rd_dat, DW'(32'h100 + i - 1));
            end
            cyc();
        end
        chk("burst_empty", DW'(rd_dat_vld), DW'(0));

        // Back-pressure: two reads accepted, then stall with a stable head
        rd_dat_rdy = 1'b0; rd_addr_vld = 1'b1; rd_addr = 10'd0;
        settle();
        chk("bp_acc0", DW'(rd_addr_rdy), DW'(1));
        cyc();
        rd_addr = 10'd1;
        settle();
        chk("bp_acc1", DW'(rd_addr_rdy), DW'(1));
        cyc();
        rd_addr = 10'd2;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("bp_stall_rdy", DW'(rd_addr_rdy), DW'(0));
            chk("bp_stall_head", rd_dat, DW'(32'h100));
            cyc();
        end
        rd_dat_rdy = 1'b1;
        settle();
        chk("bp_rel_rdy", DW'(rd_addr_rdy), DW'(1));
        chk("bp_rel_d0", rd_dat, DW'(32'h100));
        cyc();
        rd_addr = 10'd3;
        settle();
        chk("bp_rel_rdy2", DW'(rd_addr_rdy), DW'(1));
        chk("bp_rel_d1", rd_dat, DW'(32'h101));
        cyc();
        rd_addr_vld = 1'b0;
        chk("bp_rel_d2", rd_dat, DW'(32'h102));
        cyc();
        chk("bp_rel_d3", rd_dat, DW'(32'h103));
        cyc();
        chk("bp_empty", DW'(rd_dat_vld), DW'(0));

        // Write priority over a read of the same address
        wr_dat_vld = 1'b1; wr_addr = 10'd7; wr_dat = DW'(32'h55);
        rd_addr_vld = 1'b1; rd_addr = 10'd7;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("prio_wrrdy", DW'(wr_dat_rdy), DW'(1));
            chk("prio_rdrdy", DW'(rd_addr_rdy), DW'(0));
            cyc();
        end
        wr_dat_vld = 1'b0;
        settle();
        chk("prio_rd_acc", DW'(rd_addr_rdy), DW'(1));
        cyc();
        rd_addr_vld = 1'b0;
        settle();
        chk("prio_dat", rd_dat, DW'(32'h55));
        chk("prio_vld", DW'(rd_dat_vld), DW'(1));
        cyc();

        // Fill FIFO, then synchronous clear; a write during the clear is refused
        rd_dat_rdy = 1'b0; rd_addr_vld = 1'b1; rd_addr = 10'd1023;
        cyc();
        rd_addr = 10'd7;
        cyc();
        ccu_rst = 1'b1; rd_dat_rdy = 1'b1;
        wr_dat_vld = 1'b1; wr_addr = 10'd7; wr_dat = DW'(32'h99);
        settle();
        chk("clr_wrrdy", DW'(wr_dat_rdy), DW'(0));
        chk("clr_rdrdy", DW'(rd_addr_rdy), DW'(0));
        chk("clr_vld_before", DW'(rd_dat_vld), DW'(1));
        cyc();
        ccu_rst = 1'b0; wr_dat_vld = 1'b0; rd_addr_vld = 1'b0;
        settle();
        chk("clr_vld_after", DW'(rd_dat_vld), DW'(0));
        chk("clr_dat_after", rd_dat, DW'(0));
        rd_addr_vld = 1'b1; rd_addr = 10'd1023;
        cyc();
        rd_addr = 10'd7;
        settle();
        chk("clr_keep_1023", rd_dat, DW'(1));
        cyc();
        rd_addr_vld = 1'b0;
        settle();
        chk("clr_keep_7", rd_dat, DW'(32'h55));
        cyc();

        // Asynchronous reset with one entry queued
        rd_dat_rdy = 1'b0; rd_addr_vld = 1'b1; rd_addr = 10'd7;
        cyc();
        rd_addr_vld = 1'b0;
        settle();
        chk("arst_pre_vld", DW'(rd_dat_vld), DW'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_vld", DW'(rd_dat_vld), DW'(0));
        chk("arst_dat", rd_dat, DW'(0));
        chk("arst_wrrdy", DW'(wr_dat_rdy), DW'(1));
        chk("arst_rdrdy", DW'(rd_addr_rdy), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
